// File: rtl/srp16_stack_pkg.sv
// rtl/srp16_stack_pkg.sv - shared types and default limits for the stack sequencer
package srp16_stack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PUSH_WR  = 3'd1,
    ST_PUSH_ADJ = 3'd2,
    ST_POP_ADJ  = 3'd3,
    ST_POP_RD   = 3'd4,
    ST_POP_DONE = 3'd5
  } stack_state_t;

  localparam logic [15:0] STACK_BASE_DEFAULT  = 16'hFFFE;
  localparam logic [15:0] STACK_LIMIT_DEFAULT = 16'hF000;

endpackage

// File: rtl/stack_seq.sv
// rtl/stack_seq.sv - push/pop sequencer driving the external sp block and a request/ack memory port
module stack_seq
  import srp16_stack_pkg::*;
#(
  parameter logic [15:0] STACK_BASE  = STACK_BASE_DEFAULT,
  parameter logic [15:0] STACK_LIMIT = STACK_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [15:0] push_data,
  input  logic [15:0] sp_addr,
  output logic        sp_inc,
  output logic        sp_dec,
  output logic        sp_read_abus,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] pop_data,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        underflow
);

  stack_state_t r_state;
  logic [15:0]  r_word;
  logic [15:0]  r_pop_data;
  logic         r_sp_inc;
  logic         r_sp_dec;
  logic         r_sp_read_abus;
  logic         r_mem_req;
  logic         r_mem_we;
  logic         r_busy;
  logic         r_done;
  logic         r_overflow;
  logic         r_underflow;

  // Strobes and flags are produced on the transition into each state, so they
  // line up exactly with r_state and never glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_word         <= 16'h0000;
      r_pop_data     <= 16'h0000;
      r_sp_inc       <= 1'b0;
      r_sp_dec       <= 1'b0;
      r_sp_read_abus <= 1'b0;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      r_sp_inc    <= 1'b0;
      r_sp_dec    <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (push) begin
            if (sp_addr == STACK_LIMIT) begin
              r_overflow <= 1'b1;
            end else begin
              r_word         <= push_data;
              r_state        <= ST_PUSH_WR;
              r_mem_req      <= 1'b1;
              r_mem_we       <= 1'b1;
              r_sp_read_abus <= 1'b1;
              r_busy         <= 1'b1;
            end
          end else if (pop) begin
            if (sp_addr == STACK_BASE) begin
              r_underflow <= 1'b1;
            end else begin
              r_state  <= ST_POP_ADJ;
              r_sp_inc <= 1'b1;
              r_busy   <= 1'b1;
            end
          end
        end

        ST_PUSH_WR: begin
          if (mem_ack) begin
            r_state        <= ST_PUSH_ADJ;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_sp_read_abus <= 1'b0;
            r_sp_dec       <= 1'b1;
            r_done         <= 1'b1;
          end
        end

        ST_PUSH_ADJ: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end

        // SP was bumped during POP_ADJ, so sp_addr already names the top word here.
        ST_POP_ADJ: begin
          r_state        <= ST_POP_RD;
          r_mem_req      <= 1'b1;
          r_mem_we       <= 1'b0;
          r_sp_read_abus <= 1'b1;
        end

        ST_POP_RD: begin
          if (mem_ack) begin
            r_pop_data     <= mem_rdata;
            r_state        <= ST_POP_DONE;
            r_mem_req      <= 1'b0;
            r_sp_read_abus <= 1'b0;
            r_done         <= 1'b1;
          end
        end

        ST_POP_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state        <= ST_IDLE;
          r_mem_req      <= 1'b0;
          r_mem_we       <= 1'b0;
          r_sp_read_abus <= 1'b0;
          r_busy         <= 1'b0;
        end
      endcase
    end
  end

  // Address follows the live SP so a freshly incremented pointer is used in POP_RD.
  assign mem_addr     = r_mem_req ? sp_addr : 16'h0000;
  assign mem_wdata    = (r_mem_req && r_mem_we) ? r_word : 16'h0000;
  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign sp_read_abus = r_sp_read_abus;
  assign sp_inc       = r_sp_inc;
  assign sp_dec       = r_sp_dec;
  assign pop_data     = r_pop_data;
  assign busy         = r_busy;
  assign done         = r_done;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: doc/stack_seq.md
STACK_SEQ -- requirements
Module: stack_seq

Interface
REQ-001 SHALL have parameter STACK_BASE, default 16'hFFFE, the empty-stack SP value; pop refused when SP equals it.
REQ-002 SHALL have parameter STACK_LIMIT, default 16'hF000, the full-stack SP value; push refused when SP equals it.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 push  input  1  push request, sampled in IDLE only.
REQ-006 pop  input  1  pop request, sampled in IDLE only.
REQ-007 push_data  input  16  word to push, captured when push accepted.
REQ-008 sp_addr  input  16  current stack pointer from the sp block address-bus output.
REQ-009 sp_inc / sp_dec / sp_read_abus  output  1 each  control strobes to the sp block.
REQ-010 mem_req  output  1  memory request, held until mem_ack.
REQ-011 mem_we  output  1  1 = write, 0 = read; valid while mem_req is high.
REQ-012 mem_addr / mem_wdata  output  16 each  address and write data.
REQ-013 mem_ack / mem_rdata  input  1 / 16  memory completion and read data.
REQ-014 pop_data  output  16  last popped word, registered.
REQ-015 busy / done / overflow / underflow  output  1 each  status; done, overflow and underflow are single-cycle pulses.

Function
REQ-016 Convention: SP points to the next free slot, and the stack grows downward.
REQ-017 FSM states: IDLE, PUSH_WR, PUSH_ADJ, POP_ADJ, POP_RD, POP_DONE.
REQ-018 IDLE with push=1: if sp_addr==STACK_LIMIT, pulse overflow for 1 cycle and stay IDLE; otherwise latch push_data and go to PUSH_WR.
REQ-019 IDLE with pop=1 and push=0: if sp_addr==STACK_BASE, pulse underflow for 1 cycle and stay IDLE; otherwise go to POP_ADJ.
REQ-020 push and pop both high in IDLE: push has priority, and the pop is dropped without a flag.
REQ-021 PUSH_WR outputs: mem_req=1, mem_we=1, sp_read_abus=1, mem_addr=sp_addr, mem_wdata=latched word.
REQ-022 PUSH_WR exit: go to PUSH_ADJ on mem_ack; otherwise hold with all outputs stable.
REQ-023 PUSH_ADJ: sp_dec=1 and done=1 for exactly one cycle, then go to IDLE.
REQ-024 POP_ADJ: sp_inc=1 for exactly one cycle, then go to POP_RD (sp_addr is updated by the following cycle).
REQ-025 POP_RD outputs: mem_req=1, mem_we=0, sp_read_abus=1, mem_addr=sp_addr.
REQ-026 POP_RD exit: on mem_ack, register mem_rdata into pop_data and go to POP_DONE.
REQ-027 POP_DONE: done=1 for one cycle, with pop_data valid; then go to IDLE.
REQ-028 busy=1 in every state except IDLE; push and pop are ignored while busy.
REQ-029 Zero-wait memory (ack in the request cycle): push completes in 2 cycles after acceptance, pop in 3.
REQ-030 Outside PUSH_WR and POP_RD, mem_req, mem_we and sp_read_abus SHALL be 0 and mem_addr/mem_wdata SHALL be 0.
REQ-031 sp_inc and sp_dec SHALL never be asserted together, and never together with mem_req.
REQ-032 No address arithmetic in this block; the SP value is owned by the sp block, so no wrap-around handling is needed here.

Reset
REQ-033 reset=1 SHALL force IDLE immediately, independent of clk.
REQ-034 Reset SHALL clear pop_data and the latched word to 16'h0000, and drive every strobe and flag output to 0.
REQ-035 Reset mid-transaction SHALL abandon it with no sp_inc/sp_dec issued; the SP is not corrected by this block.

Structure
REQ-036 Package srp16_stack_pkg SHALL hold the state enum, STACK_BASE_DEFAULT and STACK_LIMIT_DEFAULT.
REQ-037 stack_seq SHALL be a single FSM module with no sub-module; the sp block is instantiated alongside it at top level and in the bench.

Verification
REQ-038 SP=16'hFFFE, push 16'h1234, ack same cycle -> write to FFFE with data 1234; sp_dec and done in the next cycle; SP becomes FFFD.
REQ-039 After REQ-038, pop with ack in 1 cycle -> sp_inc; read at FFFE; pop_data=1234 at the done pulse; SP becomes FFFE.
REQ-040 SP=16'hFFFE, pop -> underflow pulse only, with no mem_req and no sp_inc; SP=16'hF000, push -> overflow pulse only.
REQ-041 mem_ack delayed 3 cycles on a push -> mem_req, mem_addr and mem_wdata stable all 4 cycles; busy high throughout; a push request issued while busy is ignored.
REQ-042 push and pop both high in IDLE -> push performed, no pop, no flags.
REQ-043 reset asserted while in POP_RD -> IDLE and all outputs 0 within the same cycle; the next push proceeds normally.
